kalman_filter_mc: RTL
=====================

Name: kalman_filter_mc

Overview:
- Parametrised multi-channel scalar Kalman estimator; successor to the single-channel lock-in Kalman stage.
- Receives time-multiplexed ADC samples on AXI-Stream, tagged by channel ID.
- Every DECIM samples of a channel, runs one predict/update step for that channel and emits that channel's next-state prediction.
- Arithmetic uses one shared multiplier and an internal sequential divider, so no external Divider Generator handshake is needed.

Parameters:
ADC_WIDTH, 14, sample bits in s_axis_tdata[ADC_WIDTH-1:0] (signed)
W, 32, coefficient/state word width (signed fixed point)
F, 24, fractional bits of every W-bit quantity
N_CH, 4, channel count (1..16)
DECIM, 1024, samples per channel per filter update (power of 2, >=2)
X_INIT, 0, reset value of every channel's x_pred (Q(W-F).F)
P_INIT, 1<<F, reset value of every channel's error variance P (1.0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_axis_tdata  in  32  ADC sample in [ADC_WIDTH-1:0]; other bits ignored
s_axis_tid  in  4  channel index
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  sample accepted when tvalid&&tready
phi  in  W  state transition (1+omega*Ts)
phi_sq  in  W  phi squared
d_var  in  W  process noise variance
s_var  in  W  measurement noise variance
gain_u  in  W  control gain (oT*k_omega); u = -gain_u*y
m_axis_tdata  out  W  predicted state x_pred of updated channel
m_axis_tid  out  4  channel of m_axis_tdata
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
k_gain  out  W  Kalman gain of last update (debug)

Behaviour:
- Reset (async assert, sync release): every x_pred=X_INIT, P=P_INIT, per-channel sample counters=0; FSM=ACCUM; s_axis_tready=1; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tid=0; k_gain=0. Reset mid-update aborts the update; no partial write-back.
- Sample scaling: y = sext(sample) <<< (F-ADC_WIDTH+1), so ADC full scale maps to ±1.0.
- Multiply: full 2W product; round half-up (add 1<<(F-1)); arithmetic shift right F; saturate to W bits. Add/sub also saturates.
- ACCUM: s_axis_tready=1. Each accepted sample with tid<N_CH increments cnt[tid]. If tid>=N_CH the sample is accepted and discarded.
- When cnt[tid] reaches DECIM: cnt[tid] wraps to 0, y latches, channel latches, tready goes low the next cycle, FSM goes to PRED_P.
- PRED_P: Pp = phi_sq*P + d_var.
- PSUM: den = Pp + s_var; start the divider.
- DIV_WAIT: wait for done (F+2 cycles). K = Pp/den, clamped to [0, 1-2^-F]. If den<=0, K=0.
- UPD_X: x_est = x_pred + K*(y - x_pred).
- PRED_X: x_pred <= phi*x_est - gain_u*y.
- UPD_P1: a = (1-K)^2*Pp.
- UPD_P2: P <= a + K^2*s_var.
- OUT: m_axis_tvalid=1 with tdata=x_pred and tid=channel; k_gain=K.
- OUT exit: on m_axis_tready, go to ACCUM; tready returns to 1 the next cycle.
- Latency: m_axis_tvalid rises exactly F+9 cycles after the triggering handshake (F=24 gives 33 cycles).
- Backpressure: tdata and tid are held stable while tvalid && !tready.
- Samples are not accepted during an update; the upstream must buffer.

Optional Feature:
- KALMAN_AVG_EN defined: y is the mean of the channel's DECIM samples. Per-channel accumulator is ADC_WIDTH+log2(DECIM) bits, divided by arithmetic shift, cleared at wrap.
- Undefined: y is the sample that triggered the update; no accumulators are synthesised.

Decomposition:
- Package kalman_pkg holds the FSM state enum (ACCUM, PRED_P, PSUM, DIV_WAIT, UPD_X, PRED_X, UPD_P1, UPD_P2, OUT) and a Q-format mul/round/saturate function.
- Sub-module kalman_div: unsigned restoring divider, start/done handshake, W-bit operands, F-bit fractional quotient, latency F+2 cycles, busy ignores start.

Test Plan:
- Reset check (N_CH=2, DECIM=4, defaults): after reset, tready=1, m_axis_tvalid=0; 3 samples on ch0 -> no output.
- Single update: phi=phi_sq=s_var=0x01000000, d_var=0, gain_u=0. Fourth ch0 sample 0x1000 -> tid=0, tdata=0x00400000, k_gain=0x00800000, internal P=0x00800000, tvalid exactly 33 cycles after the handshake.
- Channel independence: interleave ch0/ch1 samples -> two outputs, ch1 result unaffected by ch0 values; tid=5 sample -> dropped, no counter change.
- Backpressure: hold m_axis_tready=0 for 20 cycles in OUT -> tdata stable, s_axis_tready=0 throughout, single transfer on release.
- Saturation: phi=0x7FFFFFFF, y=0x1FFF repeatedly -> x_pred clamps at 0x7FFFFFFF, no wrap to negative. With KALMAN_AVG_EN, samples 0,0,0,0x1000 -> y=0x00200000.
- Async reset mid DIV_WAIT -> outputs return to reset values immediately; the next update uses P_INIT/X_INIT.

Source files
------------

// File: rtl/kalman_pkg.sv
// Shared types and Q-format arithmetic for the multi-channel Kalman estimator.
package kalman_pkg;

  typedef enum logic [3:0] {
    ACCUM    = 4'd0,
    PRED_P   = 4'd1,
    PSUM     = 4'd2,
    DIV_WAIT = 4'd3,
    UPD_X    = 4'd4,
    PRED_X   = 4'd5,
    UPD_P1   = 4'd6,
    UPD_P2   = 4'd7,
    OUT      = 4'd8
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] q_sat(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    logic signed [127:0] r;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    r  = v;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    return r[63:0];
  endfunction

  // Full-precision product, round half-up, drop f fraction bits, saturate to w bits.
  function automatic logic signed [63:0] q_mul(input logic signed [63:0] a,
                                               input logic signed [63:0] b,
                                               input int f, input int w);
    logic signed [127:0] p;
    p = 128'(a) * 128'(b);
    p = p + (128'sd1 <<< (f - 1));
    p = p >>> f;
    return q_sat(p, w);
  endfunction

endpackage

// File: rtl/kalman_div.sv
// Unsigned restoring divider producing an F-bit fractional quotient num/den, saturated just below 1.0.
module kalman_div #(
  parameter int W = 32,
  parameter int F = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] num_i,
  input  logic [W-1:0] den_i,
  output logic         done_o,
  output logic [W-1:0] quo_o
);
  localparam int CW = $clog2(F + 2);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    rem_q, rem_d;
  logic [W:0]    rem_sh;
  logic [W-1:0]  den_q, den_d;
  logic [F-1:0]  quo_q, quo_d;

  // One cycle for the overflow compare, F shift/subtract steps, one cycle to flag done.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    rem_sh = {rem_q[W-1:0], 1'b0};
    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        cnt_d  = CW'(F + 1);
        rem_d  = {1'b0, num_i};
        den_d  = den_i;
        quo_d  = '0;
      end
    end else if (cnt_q == CW'(F + 1)) begin
      ovf_d = (rem_q >= {1'b0, den_q});
      cnt_d = cnt_q - CW'(1);
    end else if (cnt_q != '0) begin
      if (rem_sh >= {1'b0, den_q}) begin
        rem_d = rem_sh - {1'b0, den_q};
        quo_d = {quo_q[F-2:0], 1'b1};
      end else begin
        rem_d = rem_sh;
        quo_d = {quo_q[F-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end else begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
    end
  end

  assign done_o = done_q;
  assign quo_o  = {{(W-F){1'b0}}, (ovf_q ? {F{1'b1}} : quo_q)};

endmodule

// File: rtl/kalman_filter_mc.sv
// Multi-channel scalar Kalman estimator: one predict/update per DECIM samples of a channel.
// Define KALMAN_AVG_EN to filter the mean of each channel's DECIM samples instead of the last one.
module kalman_filter_mc
  import kalman_pkg::*;
#(
  parameter int ADC_WIDTH = 14,
  parameter int W = 32,
  parameter int F = 24,
  parameter int N_CH = 4,
  parameter int DECIM = 1024,
  parameter logic [W-1:0] X_INIT = '0,
  parameter logic [W-1:0] P_INIT = {{(W-F-1){1'b0}}, 1'b1, {F{1'b0}}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_axis_tdata,
  input  logic [3:0]   s_axis_tid,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [W-1:0] phi,
  input  logic [W-1:0] phi_sq,
  input  logic [W-1:0] d_var,
  input  logic [W-1:0] s_var,
  input  logic [W-1:0] gain_u,
  output logic [W-1:0] m_axis_tdata,
  output logic [3:0]   m_axis_tid,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [W-1:0] k_gain
);
  localparam int LOG2D = $clog2(DECIM);
  localparam int SH    = F - ADC_WIDTH + 1;
  localparam int CHI_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic signed [W-1:0] ONE = {{(W-F-1){1'b0}}, 1'b1, {F{1'b0}}};

  function automatic logic signed [W-1:0] mulq(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    return W'(q_mul(64'(a), 64'(b), F, W));
  endfunction

  function automatic logic signed [W-1:0] addq(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    return W'(q_sat(128'(a) + 128'(b), W));
  endfunction

  function automatic logic signed [W-1:0] subq(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    return W'(q_sat(128'(a) - 128'(b), W));
  endfunction

  function automatic logic signed [W-1:0] scale(input logic signed [ADC_WIDTH-1:0] s);
    logic signed [W-1:0] e;
    e = W'(s);
    return e <<< SH;
  endfunction

  state_t                   state_q, state_d;
  logic [3:0]               ch_q, ch_d;
  logic signed [W-1:0]      y_q, y_d;
  logic signed [W-1:0]      pp_q, pp_d;
  logic signed [W-1:0]      k_q, k_d;
  logic signed [W-1:0]      xe_q, xe_d;
  logic signed [W-1:0]      a_q, a_d;
  logic                     kz_q, kz_d;
  logic [W-1:0]             m_data_q, m_data_d;
  logic [3:0]               m_tid_q, m_tid_d;
  logic                     m_valid_q, m_valid_d;
  logic [W-1:0]             k_gain_q, k_gain_d;
  logic [LOG2D-1:0]         cnt_q [N_CH];
  logic [LOG2D-1:0]         cnt_d [N_CH];
  logic signed [W-1:0]      xp_q [N_CH];
  logic signed [W-1:0]      xp_d [N_CH];
  logic signed [W-1:0]      p_q [N_CH];
  logic signed [W-1:0]      p_d [N_CH];

  logic                     fire;
  logic                     in_range;
  logic [CHI_W-1:0]         idx;
  logic [CHI_W-1:0]         cidx;
  logic signed [ADC_WIDTH-1:0] samp;
  logic signed [W-1:0]      y_new;
  logic signed [W-1:0]      den;
  logic signed [W-1:0]      one_m_k;
  logic                     div_start;
  logic                     div_done;
  logic [W-1:0]             div_quo;
  logic                     unused_tdata;

  assign s_axis_tready = (state_q == ACCUM);
  assign fire          = s_axis_tvalid && s_axis_tready;
  assign in_range      = ({1'b0, s_axis_tid} < 5'(N_CH));
  assign idx           = s_axis_tid[CHI_W-1:0];
  assign cidx          = ch_q[CHI_W-1:0];
  assign samp          = s_axis_tdata[ADC_WIDTH-1:0];
  assign unused_tdata  = ^s_axis_tdata[31:ADC_WIDTH];
  assign den           = addq(pp_q, s_var);
  assign one_m_k       = subq(ONE, k_q);

`ifdef KALMAN_AVG_EN
  localparam int AW = ADC_WIDTH + LOG2D;
  logic signed [AW-1:0] acc_q [N_CH];
  logic signed [AW-1:0] acc_d [N_CH];
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] acc_mean;

  // The sum of DECIM samples always fits AW bits, so the mean fits ADC_WIDTH bits.
  assign acc_sum  = acc_q[idx] + AW'(samp);
  assign acc_mean = acc_sum >>> LOG2D;
  assign y_new    = scale(acc_mean[ADC_WIDTH-1:0]);
`else
  assign y_new    = scale(samp);
`endif

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    y_d       = y_q;
    pp_d      = pp_q;
    k_d       = k_q;
    xe_d      = xe_q;
    a_d       = a_q;
    kz_d      = kz_q;
    m_data_d  = m_data_q;
    m_tid_d   = m_tid_q;
    m_valid_d = m_valid_q;
    k_gain_d  = k_gain_q;
    cnt_d     = cnt_q;
    xp_d      = xp_q;
    p_d       = p_q;
    div_start = 1'b0;
`ifdef KALMAN_AVG_EN
    acc_d     = acc_q;
`endif
    case (state_q)
      ACCUM: begin
        if (fire && in_range) begin
          if (cnt_q[idx] == LOG2D'(DECIM - 1)) begin
            cnt_d[idx] = '0;
            y_d        = y_new;
            ch_d       = s_axis_tid;
            state_d    = PRED_P;
`ifdef KALMAN_AVG_EN
            acc_d[idx] = '0;
`endif
          end else begin
            cnt_d[idx] = cnt_q[idx] + LOG2D'(1);
`ifdef KALMAN_AVG_EN
            acc_d[idx] = acc_sum;
`endif
          end
        end
      end
      PRED_P: begin
        pp_d    = addq(mulq(phi_sq, p_q[cidx]), d_var);
        state_d = PSUM;
      end
      PSUM: begin
        // A non-positive denominator or prior variance forces the gain to zero.
        div_start = 1'b1;
        kz_d      = den[W-1] || (den == '0) || pp_q[W-1];
        state_d   = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (div_done) begin
          k_d     = kz_q ? '0 : div_quo;
          state_d = UPD_X;
        end
      end
      UPD_X: begin
        xe_d    = addq(xp_q[cidx], mulq(k_q, subq(y_q, xp_q[cidx])));
        state_d = PRED_X;
      end
      PRED_X: begin
        xp_d[cidx] = subq(mulq(phi, xe_q), mulq(gain_u, y_q));
        state_d    = UPD_P1;
      end
      UPD_P1: begin
        a_d     = mulq(mulq(one_m_k, one_m_k), pp_q);
        state_d = UPD_P2;
      end
      UPD_P2: begin
        p_d[cidx] = addq(a_q, mulq(mulq(k_q, k_q), s_var));
        m_data_d  = xp_q[cidx];
        m_tid_d   = ch_q;
        k_gain_d  = k_q;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_axis_tready) begin
          m_valid_d = 1'b0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ACCUM;
      ch_q      <= '0;
      y_q       <= '0;
      pp_q      <= '0;
      k_q       <= '0;
      xe_q      <= '0;
      a_q       <= '0;
      kz_q      <= 1'b0;
      m_data_q  <= '0;
      m_tid_q   <= '0;
      m_valid_q <= 1'b0;
      k_gain_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        xp_q[i]  <= X_INIT;
        p_q[i]   <= P_INIT;
`ifdef KALMAN_AVG_EN
        acc_q[i] <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      y_q       <= y_d;
      pp_q      <= pp_d;
      k_q       <= k_d;
      xe_q      <= xe_d;
      a_q       <= a_d;
      kz_q      <= kz_d;
      m_data_q  <= m_data_d;
      m_tid_q   <= m_tid_d;
      m_valid_q <= m_valid_d;
      k_gain_q  <= k_gain_d;
      cnt_q     <= cnt_d;
      xp_q      <= xp_d;
      p_q       <= p_d;
`ifdef KALMAN_AVG_EN
      acc_q     <= acc_d;
`endif
    end
  end

  kalman_div #(
    .W(W),
    .F(F)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .start_i(div_start),
    .num_i  (pp_q),
    .den_i  (den),
    .done_o (div_done),
    .quo_o  (div_quo)
  );

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tvalid = m_valid_q;
  assign k_gain        = k_gain_q;

endmodule
